// File: rtl/ahb3_pkg.sv
// Shared AHB3-Lite encodings for the hs32 simulation bus models.
package ahb3_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam logic [2:0] HSIZE_WORD = 3'd2;

endpackage

// File: rtl/ahb3_dummy_slave.sv
// AHB3-Lite word memory slave, zero wait states by default.
// Define AHB3_DUMMY_WAIT_EN to insert WAITCYCLES wait states per OKAY data phase.
module ahb3_dummy_slave
  import ahb3_pkg::*;
#(
  parameter int ADDRSIZE = 8,
  parameter int tpd      = 0
`ifdef AHB3_DUMMY_WAIT_EN
  , parameter int WAITCYCLES = 1
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] HADDR_i,
  input  logic        HWRITE_i,
  input  logic [2:0]  HSIZE_i,
  input  logic [2:0]  HBURST_i,
  input  logic [3:0]  HPROT_i,
  input  logic [1:0]  HTRANS_i,
  input  logic        HMASTLOCK_i,
  input  logic [31:0] HWDATA_i,
  output logic        HREADY_o,
  output logic        HRESP_o,
  output logic [31:0] HRDATA_o
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e      state, state_nxt;
  logic        active, hwrite;
  logic [31:0] haddr;
  logic [2:0]  size;
  logic [31:0] mem [2**ADDRSIZE];
  logic        ready, accept;
  state_e      ok_state;

`ifdef AHB3_DUMMY_WAIT_EN
  localparam int unsigned WCW = (WAITCYCLES > 1) ? $clog2(WAITCYCLES) : 1;
  logic [WCW-1:0] wait_cnt;
  logic           wait_last;
  assign ok_state  = (WAITCYCLES > 0) ? S_WAIT : S_DATA;
  assign wait_last = (wait_cnt == WCW'(WAITCYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                     wait_cnt <= '0;
  end
`else
  logic wait_last;
  assign ok_state  = S_DATA;
  assign wait_last = 1'b1;
`endif

  always_comb begin
    ready     = (state != S_WAIT) && (state != S_ERR1);
    accept    = ready && ((HTRANS_i == HTRANS_NONSEQ) || (HTRANS_i == HTRANS_SEQ));
    state_nxt = state;
    if (ready) begin
      if (!accept)                   state_nxt = S_IDLE;
      else if (HSIZE_i > HSIZE_WORD) state_nxt = S_ERR1;
      else                           state_nxt = ok_state;
    end else begin
      case (state)
        S_ERR1:  state_nxt = S_ERR2;
        S_WAIT:  state_nxt = wait_last ? S_DATA : S_WAIT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Address phase registers hold while the slave stalls (HREADY_o low).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      active <= 1'b0;
      hwrite <= 1'b0;
      haddr  <= '0;
      size   <= '0;
    end else begin
      state <= state_nxt;
      if (ready) begin
        active <= accept;
        hwrite <= accept && HWRITE_i;
        if (accept) begin
          haddr <= HADDR_i;
          size  <= HSIZE_i;
        end
      end
    end
  end

  // Only an OKAY data phase in its final (ready) cycle commits a write.
  always_ff @(posedge clk) begin
    if (state == S_DATA && active && hwrite)
      mem[haddr[ADDRSIZE-1:0]] <= HWDATA_i;
  end

  // tpd is a simulation-only output delay; this view models no delay.
  assign HREADY_o = ready;
  assign HRESP_o  = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA_o = (active && !hwrite) ? mem[haddr[ADDRSIZE-1:0]] : '0;

  logic unused_ok;
  assign unused_ok = &{1'b0, HBURST_i, HPROT_i, HMASTLOCK_i, haddr, size, (tpd != 0)};

endmodule

// File: tb/tb_ahb3_dummy_slave.sv
// Randomized bench for ahb3_dummy_slave against a transfer-schedule model.
module tb_ahb3_dummy_slave;

`ifdef AHB3_DUMMY_WAIT_EN
  localparam int WAITN = 1;
`else
  localparam int WAITN = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] HADDR_i, HWDATA_i, HRDATA_o;
  logic        HWRITE_i, HMASTLOCK_i, HREADY_o, HRESP_o;
  logic [2:0]  HSIZE_i, HBURST_i;
  logic [3:0]  HPROT_i;
  logic [1:0]  HTRANS_i;

  ahb3_dummy_slave #(.ADDRSIZE(8)) dut (
    .clk(clk), .resetn(resetn), .HADDR_i(HADDR_i), .HWRITE_i(HWRITE_i),
    .HSIZE_i(HSIZE_i), .HBURST_i(HBURST_i), .HPROT_i(HPROT_i), .HTRANS_i(HTRANS_i),
    .HMASTLOCK_i(HMASTLOCK_i), .HWDATA_i(HWDATA_i), .HREADY_o(HREADY_o),
    .HRESP_o(HRESP_o), .HRDATA_o(HRDATA_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  // Model: word array plus the one outstanding data phase and its response schedule.
  logic [31:0] mm [256];
  logic        dp_valid = 1'b0, dp_write = 1'b0, dp_err = 1'b0;
  logic [7:0]  dp_addr = '0;
  int          dp_idx = 0;

  function automatic logic exp_ready();
    if (!dp_valid) return 1'b1;
    return dp_err ? (dp_idx == 1) : (dp_idx == WAITN);
  endfunction

  function automatic logic exp_resp();
    return dp_valid && dp_err;
  endfunction

  function automatic logic [31:0] exp_rdata();
    return (dp_valid && !dp_write) ? mm[dp_addr] : 32'h0;
  endfunction

  initial for (int i = 0; i < 256; i++) mm[i] = 32'h0;

  always @(posedge clk) begin
    logic rdy;
    if (!resetn) begin
      dp_valid = 1'b0;
    end else begin
      rdy = exp_ready();
      if (dp_valid) begin
        if (rdy) begin
          if (!dp_err && dp_write) mm[dp_addr] = HWDATA_i;
          dp_valid = 1'b0;
        end else begin
          dp_idx++;
        end
      end
      if (rdy && HTRANS_i[1]) begin
        dp_valid = 1'b1;
        dp_write = HWRITE_i;
        dp_addr  = HADDR_i[7:0];
        dp_err   = (HSIZE_i > 3'd2);
        dp_idx   = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en && resetn) begin
      chk("hready", {31'h0, HREADY_o}, {31'h0, exp_ready()});
      chk("hresp",  {31'h0, HRESP_o},  {31'h0, exp_resp()});
      chk("hrdata", HRDATA_o, exp_rdata());
    end
  end

  task automatic cyc(input logic [1:0] tr, input logic wr, input logic [31:0] ad,
                     input logic [2:0] sz, input logic [31:0] wd);
    @(posedge clk);
    #1;
    HTRANS_i = tr; HWRITE_i = wr; HADDR_i = ad; HSIZE_i = sz; HWDATA_i = wd;
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    HTRANS_i = 2'd0; HWRITE_i = 1'b0; HADDR_i = '0; HSIZE_i = 3'd2; HWDATA_i = '0;
    HBURST_i = '0; HPROT_i = '0; HMASTLOCK_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hready", {31'h0, HREADY_o}, 32'h1);
    chk("rst_hresp",  {31'h0, HRESP_o},  32'h0);
    chk("rst_hrdata", HRDATA_o, 32'h0);
    @(posedge clk); #1; resetn = 1'b1; check_en = 1'b1;

    // Define every word so reads never depend on power-up contents.
    for (int i = 0; i < 256; i++) cyc(2'd2, 1'b1, i, 3'd2, 32'h0);
    cyc(2'd0, 1'b0, 32'h0, 3'd2, 32'h0);

`ifndef AHB3_DUMMY_WAIT_EN
    cyc(2'd2, 1'b1, 32'd5, 3'd2, 32'h0);
    cyc(2'd2, 1'b0, 32'd5, 3'd2, 32'hDEADBEEF);
    cyc(2'd0, 1'b0, 32'd0, 3'd2, 32'h0);
    chk("wr_rd_5", HRDATA_o, 32'hDEADBEEF);
    chk("wr_rd_ready", {31'h0, HREADY_o}, 32'h1);

    cyc(2'd2, 1'b1, 32'd1, 3'd2, 32'h0);
    cyc(2'd3, 1'b1, 32'd2, 3'd2, 32'h11);
    cyc(2'd2, 1'b0, 32'd2, 3'd2, 32'h22);
    cyc(2'd3, 1'b0, 32'd1, 3'd2, 32'h0);
    chk("b2b_rd2", HRDATA_o, 32'h22);
    cyc(2'd0, 1'b0, 32'd0, 3'd2, 32'h0);
    chk("b2b_rd1", HRDATA_o, 32'h11);

    cyc(2'd2, 1'b1, 32'h100, 3'd2, 32'h0);
    cyc(2'd2, 1'b0, 32'h000, 3'd2, 32'hA5A5A5A5);
    cyc(2'd0, 1'b0, 32'd0, 3'd2, 32'h0);
    chk("alias_0", HRDATA_o, 32'hA5A5A5A5);

    cyc(2'd2, 1'b1, 32'd7, 3'd3, 32'h0);
    cyc(2'd0, 1'b0, 32'd0, 3'd2, 32'h99999999);
    chk("err1_ready", {31'h0, HREADY_o}, 32'h0);
    chk("err1_resp",  {31'h0, HRESP_o},  32'h1);
    cyc(2'd2, 1'b0, 32'd7, 3'd2, 32'h99999999);
    chk("err2_ready", {31'h0, HREADY_o}, 32'h1);
    chk("err2_resp",  {31'h0, HRESP_o},  32'h1);
    cyc(2'd0, 1'b0, 32'd0, 3'd2, 32'h0);
    chk("err_rd7", HRDATA_o, 32'h0);
    chk("err_after_resp", {31'h0, HRESP_o}, 32'h0);
`endif

    for (int n = 0; n < 2000; n++) begin
      logic [2:0] sz;
      int r;
      r  = $urandom_range(0, 15);
      sz = (r == 0) ? 3'($urandom_range(3, 7)) : (r == 1) ? 3'($urandom_range(0, 1)) : 3'd2;
      HBURST_i = 3'($urandom); HPROT_i = 4'($urandom); HMASTLOCK_i = 1'($urandom);
      cyc(2'($urandom), 1'($urandom), $urandom & 32'hFFFF_F00F, sz, $urandom);
    end
    repeat (3) cyc(2'd0, 1'b0, 32'h0, 3'd2, 32'h0);

`ifndef AHB3_DUMMY_WAIT_EN
    // Reset during a write data phase, then during a read data phase.
    cyc(2'd2, 1'b1, 32'd9, 3'd2, 32'h0);
    cyc(2'd2, 1'b1, 32'd9, 3'd2, 32'h0BADF00D);
    @(posedge clk); #1;
    HTRANS_i = 2'd0; HWDATA_i = 32'h12345678; check_en = 1'b0;
    #2 resetn = 1'b0;
    #1 chk("midrst_ready", {31'h0, HREADY_o}, 32'h1);
    chk("midrst_resp", {31'h0, HRESP_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1; check_en = 1'b1;
    cyc(2'd2, 1'b0, 32'd9, 3'd2, 32'h0);
    cyc(2'd0, 1'b0, 32'd0, 3'd2, 32'h0);
    chk("midrst_word9", HRDATA_o, 32'h0BADF00D);
    check_en = 1'b0;
    #1 resetn = 1'b0;
    #1 chk("midrst_rd_hrdata", HRDATA_o, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1; check_en = 1'b1;
    repeat (2) cyc(2'd0, 1'b0, 32'd0, 3'd2, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
